// File: rtl/iso14443a_pcd_miller_tx_if.sv
// Bit-stream handshake between the frame builder and the Type A reader transmitter.
// The master presents one bit at a time and the slave strobes tx_ready when it takes the bit.
interface iso14443a_pcd_miller_tx_if;
  logic tx_data;
  logic tx_last;
  logic tx_valid;
  logic tx_ready;

  modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/iso14443a_pcd_miller_tx.sv
// ISO/IEC 14443-2 Type A reader-side transmitter: Modified-Miller encodes a serial bit stream
// into the registered pause envelope pause_n, framed by SOC and EOC.
module iso14443a_pcd_miller_tx #(
  parameter int BIT_CLOCKS = 128,
  parameter int PAUSE_LEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  iso14443a_pcd_miller_tx_if.slave tx,
  output logic                     pause_n,
  output logic                     busy,
  output logic                     underflow
);

  localparam int CW = $clog2(BIT_CLOCKS);
  localparam logic [CW-1:0] C_LAST  = CW'(BIT_CLOCKS - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(BIT_CLOCKS / 2);
  localparam logic [CW-1:0] C_PAUSE = CW'(PAUSE_LEN);
  localparam logic [CW-1:0] C_XEND  = CW'(BIT_CLOCKS / 2 + PAUSE_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SOC, S_DATA, S_EOC0, S_EOCY} state_e;
  typedef enum logic [1:0] {SEQ_Z, SEQ_X, SEQ_Y} seq_e;

  state_e        state_q, state_d;
  seq_e          seq_q, seq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          prev_zero_q, prev_zero_d;  // symbol in flight is SOC or a logical '0'
  logic          underflow_d;
  logic          busy_d;
  logic          pause_n_d;
  logic          period_end;

  // '1' is always X; '0' is Z only after SOC or another '0', otherwise Y.
  function automatic seq_e encode(input logic bit_val, input logic prev_zero);
    if (bit_val)   return SEQ_X;
    if (prev_zero) return SEQ_Z;
    return SEQ_Y;
  endfunction

  assign period_end = (cnt_q == C_LAST);
  assign tx.tx_ready = period_end &&
                       ((state_q == S_SOC) || ((state_q == S_DATA) && !last_q));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    seq_d       = seq_q;
    last_d      = last_q;
    prev_zero_d = prev_zero_q;
    underflow_d = 1'b0;
    cnt_d       = ((state_q == S_IDLE) || period_end) ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx.tx_valid) begin
          state_d     = S_SOC;
          seq_d       = SEQ_Z;
          last_d      = 1'b0;
          prev_zero_d = 1'b1;
        end
      end
      S_SOC, S_DATA: begin
        if (period_end) begin
          if ((state_q == S_DATA) && last_q) begin
            state_d     = S_EOC0;
            seq_d       = encode(1'b0, prev_zero_q);
            prev_zero_d = 1'b1;
          end else if (tx.tx_valid) begin
            state_d     = S_DATA;
            last_d      = tx.tx_last;
            seq_d       = encode(tx.tx_data, prev_zero_q);
            prev_zero_d = !tx.tx_data;
          end else begin
            // Starved mid-frame: close the frame cleanly rather than stall the carrier.
            underflow_d = 1'b1;
            state_d     = S_EOC0;
            seq_d       = encode(1'b0, prev_zero_q);
            prev_zero_d = 1'b1;
          end
        end
      end
      S_EOC0: begin
        if (period_end) begin
          state_d = S_EOCY;
          seq_d   = SEQ_Y;
        end
      end
      S_EOCY: begin
        if (period_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so the registered envelope lines up with c=0.
    busy_d    = (state_d != S_IDLE);
    pause_n_d = !(busy_d &&
                  (((seq_d == SEQ_Z) && (cnt_d < C_PAUSE)) ||
                   ((seq_d == SEQ_X) && (cnt_d >= C_HALF) && (cnt_d < C_XEND))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      seq_q       <= SEQ_Y;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      prev_zero_q <= 1'b1;
      pause_n     <= 1'b1;
      busy        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      prev_zero_q <= prev_zero_d;
      pause_n     <= pause_n_d;
      busy        <= busy_d;
      underflow   <= underflow_d;
    end
  end

endmodule
